// File: rtl/npu_conv_pkg.sv
// -----------------------------------------------------------------------------
// npu_conv_pkg
// Shared constants and helpers for the NPU convolution window datapath.
//   DEF_BIT_DEPTH / DEF_KERNEL : default pixel width and kernel size
//   last_start()               : image column of the last window start in a row
//   col_width()                : width of a column counter for a given row width
// -----------------------------------------------------------------------------
package npu_conv_pkg;

   localparam int DEF_BIT_DEPTH = 8;
   localparam int DEF_KERNEL    = 3;

   // Largest window start column reachable on the stride grid of one row.
   function automatic int last_start(input int img_width, input int kernel,
                                     input int stride);
      return ((img_width - kernel) / stride) * stride;
   endfunction

   // Counter width for 0..img_width-1; never narrower than one bit.
   function automatic int col_width(input int img_width);
      return (img_width > 1) ? $clog2(img_width) : 1;
   endfunction

endpackage : npu_conv_pkg

// File: rtl/window_shift_row.sv
// -----------------------------------------------------------------------------
// window_shift_row
// One row of the KxK window: a KERNEL-deep, BIT_DEPTH-wide shift register.
// On load every element moves one slot toward index 0 (oldest) and the new
// pixel enters at index KERNEL-1 (newest).
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset, zeroes the row
//   clear   : synchronous row restart, zeroes the row
//   load    : shift in din this cycle
//   din     : incoming pixel for this row
//   row_out : element c at [c*BIT_DEPTH +: BIT_DEPTH]
// -----------------------------------------------------------------------------
module window_shift_row #(
   parameter int BIT_DEPTH = 8,
   parameter int KERNEL    = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        load,
   input  logic [BIT_DEPTH-1:0]        din,
   output logic [KERNEL*BIT_DEPTH-1:0] row_out
);

   logic [BIT_DEPTH-1:0] elem [KERNEL];

   // NOTE: the window storage is reset because downstream logic relies on
   // win_out reading all-zero after reset or clear, not just on out_valid.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         for (int c = 0; c < KERNEL; c++) elem[c] <= '0;
      end else if (load) begin
         // NOTE: non-blocking assignments make every element read its
         // neighbour's pre-edge value, so the loop order does not matter.
         for (int c = 0; c < KERNEL - 1; c++) elem[c] <= elem[c+1];
         elem[KERNEL-1] <= din;
      end
   end

   for (genvar c = 0; c < KERNEL; c++) begin : g_pack
      assign row_out[c*BIT_DEPTH +: BIT_DEPTH] = elem[c];
   end

endmodule : window_shift_row

// File: rtl/conv_window_kxk.sv
// -----------------------------------------------------------------------------
// conv_window_kxk
// KxK sliding-window generator. Each accepted beat is one image column of
// KERNEL vertically adjacent pixels; a window is emitted only when all KERNEL
// columns belong to the same image row and the window start is on the stride
// grid. Output is a registered valid/ready stage with backpressure.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous row restart (drops any same-cycle input column)
//   in_valid / in_ready / in_col    : column input handshake
//   out_valid / out_ready / win_out : window output handshake
//   out_col    : image column of window element c=0
//   out_last   : final window of the current row
// Parameter limits: KERNEL >= 1, IMG_WIDTH >= KERNEL, 1 <= STRIDE <= KERNEL.
// -----------------------------------------------------------------------------
module conv_window_kxk
   import npu_conv_pkg::*;
#(
   parameter int BIT_DEPTH = DEF_BIT_DEPTH,
   parameter int KERNEL    = DEF_KERNEL,
   parameter int IMG_WIDTH = 8,
   parameter int STRIDE    = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [KERNEL*BIT_DEPTH-1:0]         in_col,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [KERNEL*KERNEL*BIT_DEPTH-1:0]  win_out,
   output logic [col_width(IMG_WIDTH)-1:0]     out_col,
   output logic                                out_last
);

   localparam int CW  = col_width(IMG_WIDTH);
   // One extra bit so STRIDE (which may equal IMG_WIDTH) and the wrapped
   // start value fit without truncation.
   localparam int CWE = CW + 1;

   localparam logic [CWE-1:0] K_M1     = CWE'(KERNEL - 1);
   localparam logic [CWE-1:0] STRIDE_E = CWE'(STRIDE);
   localparam logic [CWE-1:0] LAST_E   = CWE'(last_start(IMG_WIDTH, KERNEL, STRIDE));
   localparam logic [CW-1:0]  COL_MAX  = CW'(IMG_WIDTH - 1);

   logic [CW-1:0]  col_cnt;
   logic           accept;
   logic           load;
   logic [CWE-1:0] start;
   logic           full_window;
   logic           on_stride;

   // A held window blocks new columns unless it is being consumed this cycle,
   // which lets a consume and the next load share one edge.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign load     = accept && !clear;

   // Window start column for the column being accepted (pre-increment count).
   assign start       = {1'b0, col_cnt} - K_M1;
   assign full_window = ({1'b0, col_cnt} >= K_M1);
   assign on_stride   = ((start % STRIDE_E) == '0);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         col_cnt   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_col   <= '0;
      end else if (accept) begin
         col_cnt   <= (col_cnt == COL_MAX) ? '0 : col_cnt + 1'b1;
         out_valid <= full_window && on_stride;
         out_col   <= start[CW-1:0];
         out_last  <= (start == LAST_E);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   // Row r of the window is fed by pixel r of the incoming column.
   for (genvar r = 0; r < KERNEL; r++) begin : g_row
      window_shift_row #(
         .BIT_DEPTH (BIT_DEPTH),
         .KERNEL    (KERNEL)
      ) u_row (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear   (clear),
         .load    (load),
         .din     (in_col[r*BIT_DEPTH +: BIT_DEPTH]),
         .row_out (win_out[r*KERNEL*BIT_DEPTH +: KERNEL*BIT_DEPTH])
      );
   end

endmodule : conv_window_kxk

// File: tb/tb_conv_window_kxk.sv
// -----------------------------------------------------------------------------
// tb_conv_window_kxk
// Directed bench for conv_window_kxk. Two instances share all inputs: the
// default configuration (K=3, W=8, S=1) and a STRIDE=2 variant. Pixel values
// are 16*r + n for row r of global column n, so every expected window is
// computed from its start column alone.
// -----------------------------------------------------------------------------
module tb_conv_window_kxk;

   localparam int BD = 8;
   localparam int K  = 3;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          in_valid;
   logic [K*BD-1:0] in_col;
   logic          out_ready;

   logic            in_ready,  in_ready_s2;
   logic            out_valid, out_valid_s2;
   logic [K*K*BD-1:0] win_out, win_out_s2;
   logic [2:0]      out_col,   out_col_s2;
   logic            out_last,  out_last_s2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_window_kxk #(.BIT_DEPTH(BD), .KERNEL(K), .IMG_WIDTH(W), .STRIDE(1)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
      .out_valid(out_valid), .out_ready(out_ready), .win_out(win_out),
      .out_col(out_col), .out_last(out_last)
   );

   conv_window_kxk #(.BIT_DEPTH(BD), .KERNEL(K), .IMG_WIDTH(W), .STRIDE(2)) dut_s2 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready_s2), .in_col(in_col),
      .out_valid(out_valid_s2), .out_ready(out_ready), .win_out(win_out_s2),
      .out_col(out_col_s2), .out_last(out_last_s2)
   );

   function automatic logic [K*BD-1:0] make_col(input int n);
      logic [K*BD-1:0] v;
      for (int r = 0; r < K; r++) v[r*BD +: BD] = BD'(16*r + n);
      return v;
   endfunction

   function automatic logic [K*K*BD-1:0] exp_win(input int s);
      logic [K*K*BD-1:0] v;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            v[(r*K+c)*BD +: BD] = BD'(16*r + s + c);
      return v;
   endfunction

   // Advance one edge; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int n);
      in_valid = 1'b1;
      in_col   = make_col(n);
      tick();
   endtask

   task automatic do_clear();
      in_valid = 1'b0;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
   endtask

   task automatic test_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_col    = make_col(50);
      rst_n     = 1'b0;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (win_out !== '0) begin errors++;
         $display("FAIL reset_win_out got %h want 0", win_out); end
      checks++; if (out_col !== 3'd0) begin errors++;
         $display("FAIL reset_out_col got %0d want 0", out_col); end
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready); end
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   // First row after reset: also shows the reset-cycle column was not taken.
   task automatic test_stream();
      int wins = 0;
      for (int n = 0; n < W; n++) begin
         push(n);
         checks++; if (out_valid !== (n >= K-1)) begin errors++;
            $display("FAIL stream_valid col %0d got %b want %b", n, out_valid, n >= K-1); end
         if (n >= K-1) begin
            wins++;
            checks++; if (out_col !== 3'(n-2)) begin errors++;
               $display("FAIL stream_out_col got %0d want %0d", out_col, n-2); end
            checks++; if (win_out !== exp_win(n-2)) begin errors++;
               $display("FAIL stream_win start %0d got %h want %h", n-2, win_out, exp_win(n-2)); end
            checks++; if (out_last !== (n-2 == 5)) begin errors++;
               $display("FAIL stream_last start %0d got %b want %b", n-2, out_last, n-2 == 5); end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++;
         $display("FAIL stream_consume got valid %b last %b want 0 0", out_valid, out_last); end
      checks++; if (wins !== 6) begin errors++;
         $display("FAIL stream_count got %0d want 6", wins); end
   endtask

   task automatic test_backpressure();
      do_clear();
      out_ready = 1'b0;
      for (int n = 0; n < K; n++) push(n);
      in_valid = 1'b1;
      in_col   = make_col(3);
      for (int i = 0; i < 4; i++) begin
         checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || win_out !== exp_win(0) || out_col !== 3'd0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got v%b col %0d win %h want v1 col 0 win %h",
                     i, out_valid, out_col, win_out, exp_win(0)); end
         tick();
      end
      out_ready = 1'b1;
      for (int n = 3; n < W; n++) begin
         push(n);
         checks++; if (out_valid !== 1'b1 || out_col !== 3'(n-2) || win_out !== exp_win(n-2)) begin
            errors++;
            $display("FAIL bp_resume got v%b col %0d win %h want v1 col %0d win %h",
                     out_valid, out_col, win_out, n-2, exp_win(n-2)); end
      end
      checks++; if (out_last !== 1'b1) begin errors++;
         $display("FAIL bp_last got %b want 1", out_last); end
   endtask

   // Continues directly after test_backpressure's full row.
   task automatic test_row_wrap();
      for (int n = 8; n < 16; n++) begin
         push(n);
         if (n < 10) begin
            checks++; if (out_valid !== 1'b0) begin errors++;
               $display("FAIL wrap_no_window col %0d got %b want 0", n, out_valid); end
         end else begin
            checks++; if (out_valid !== 1'b1 || out_col !== 3'(n-10) || win_out !== exp_win(n-2)) begin
               errors++;
               $display("FAIL wrap_window got v%b col %0d win %h want v1 col %0d win %h",
                        out_valid, out_col, win_out, n-10, exp_win(n-2)); end
            checks++; if (out_last !== (n == 15)) begin errors++;
               $display("FAIL wrap_last col %0d got %b want %b", n, out_last, n == 15); end
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_stride2();
      int wins = 0;
      do_clear();
      for (int n = 0; n < W; n++) begin
         logic exp_v;
         exp_v = (n >= 2) && ((n - 2) % 2 == 0);
         push(n);
         checks++; if (out_valid_s2 !== exp_v) begin errors++;
            $display("FAIL s2_valid col %0d got %b want %b", n, out_valid_s2, exp_v); end
         if (exp_v) begin
            wins++;
            checks++; if (out_col_s2 !== 3'(n-2) || win_out_s2 !== exp_win(n-2)) begin errors++;
               $display("FAIL s2_window got col %0d win %h want col %0d win %h",
                        out_col_s2, win_out_s2, n-2, exp_win(n-2)); end
            checks++; if (out_last_s2 !== (n == 6)) begin errors++;
               $display("FAIL s2_last col %0d got %b want %b", n, out_last_s2, n == 6); end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (wins !== 3) begin errors++;
         $display("FAIL s2_count got %0d want 3", wins); end
   endtask

   // Interrupt a row after its 4th accept with clear (or reset) while a
   // column is offered; that column must be dropped.
   task automatic test_interrupt(input bit use_reset);
      string tag;
      tag = use_reset ? "rst" : "clr";
      do_clear();
      for (int n = 0; n < 4; n++) push(n);
      checks++; if (out_valid !== 1'b1) begin errors++;
         $display("FAIL %s_pre_valid got %b want 1", tag, out_valid); end
      in_valid = 1'b1;
      in_col   = make_col(4);
      if (use_reset) rst_n = 1'b0; else clear = 1'b1;
      tick();
      rst_n = 1'b1;
      clear = 1'b0;
      checks++; if (out_valid !== 1'b0 || win_out !== '0 || out_col !== 3'd0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL %s_state got v%b col %0d last %b win %h want v0 col 0 last 0 win 0",
                  tag, out_valid, out_col, out_last, win_out); end
      for (int n = 20; n < 22; n++) begin
         push(n);
         checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL %s_no_window col %0d got %b want 0", tag, n, out_valid); end
      end
      push(22);
      checks++; if (out_valid !== 1'b1 || out_col !== 3'd0 || win_out !== exp_win(20)) begin
         errors++;
         $display("FAIL %s_first_window got v%b col %0d win %h want v1 col 0 win %h",
                  tag, out_valid, out_col, win_out, exp_win(20)); end
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_col    = '0;
      out_ready = 1'b1;
      tick();
      test_reset();
      test_stream();
      test_backpressure();
      test_row_wrap();
      test_stride2();
      test_interrupt(1'b0);
      test_interrupt(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_conv_window_kxk
